// File: rtl/mips_multi_ctrl.sv
// Multicycle MIPS control unit with memory request/ready handshake and sticky error state.
// Optional wait-state watchdog is built when MULTI_WAIT_TIMEOUT_EN is defined.
module mips_multi_ctrl #(
  parameter int ALUCTL_W = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                memreq,
  output logic                pcen,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regwrite,
  output logic                alusrca,
  output logic                iord,
  output logic                memtoreg,
  output logic                regdst,
  output logic                zeroext,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                err,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11,
    S_ERROR   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  state_t     state, state_n;
  logic       err_q;
  logic       wait_hit;
  logic       funct_ok;
  logic [3:0] rtype_alu;
  logic [3:0] imm_alu;
  logic [3:0] alu4;
  logic       memreq_s, memwrite_s, irwrite_s, regwrite_s, pcwrite_s, branch_s;

`ifdef MULTI_WAIT_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       is_mem_state;

  assign is_mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // Counter value equal to MAX_WAIT means MAX_WAIT wait cycles have already been tolerated.
  assign wait_hit     = is_mem_state && (wait_cnt == 8'(MAX_WAIT)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= 8'd0;
    else if (state_n != state)
      wait_cnt <= 8'd0;
    else if (is_mem_state && !mem_ready)
      wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign wait_hit = 1'b0;
`endif

  always_comb begin
    funct_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b100110: rtype_alu = ALU_XOR;
      6'b100111: rtype_alu = ALU_NOR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    imm_alu = ALU_ADD;
    case (op)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      OP_SLTI: imm_alu = ALU_SLT;
      default: imm_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)     state_n = S_DECODE;
        else if (wait_hit) state_n = S_ERROR;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                        state_n = S_MEMADR;
          OP_RTYPE:                            state_n = S_RTYPEEX;
          OP_BEQ, OP_BNE:                      state_n = S_BREX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_n = S_IMMEX;
          OP_J:                                state_n = S_JEX;
          default:                             state_n = S_ERROR;
        endcase
      end
      S_MEMADR:  state_n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)     state_n = S_MEMWB;
        else if (wait_hit) state_n = S_ERROR;
      end
      S_MEMWR: begin
        if (mem_ready)     state_n = S_FETCH;
        else if (wait_hit) state_n = S_ERROR;
      end
      S_MEMWB:   state_n = S_FETCH;
      S_RTYPEEX: state_n = funct_ok ? S_RTYPEWB : S_ERROR;
      S_RTYPEWB: state_n = S_FETCH;
      S_BREX:    state_n = S_FETCH;
      S_IMMEX:   state_n = S_IMMWB;
      S_IMMWB:   state_n = S_FETCH;
      S_JEX:     state_n = S_FETCH;
      S_ERROR:   state_n = S_ERROR;
      default:   state_n = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == S_ERROR) err_q <= 1'b1;
    end
  end

  always_comb begin
    memreq_s   = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    zeroext    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alu4       = ALU_ADD;
    case (state)
      S_FETCH: begin
        memreq_s  = 1'b1;
        alusrcb   = 2'b01;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memreq_s = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWR: begin
        memreq_s   = 1'b1;
        iord       = 1'b1;
        memwrite_s = mem_ready;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alu4    = rtype_alu;
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      S_BREX: begin
        alusrca  = 1'b1;
        alu4     = ALU_SUB;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu4    = imm_alu;
        zeroext = (op == OP_ANDI) || (op == OP_ORI);
      end
      S_IMMWB:   regwrite_s = 1'b1;
      S_JEX: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables and the memory request are suppressed whenever reset is high.
  assign memreq   = !reset && memreq_s;
  assign memwrite = !reset && memwrite_s;
  assign irwrite  = !reset && irwrite_s;
  assign regwrite = !reset && regwrite_s;
  assign pcen     = !reset && (pcwrite_s || (branch_s && (zero ^ (op == OP_BNE))));

  always_comb begin
    alucontrol      = '0;
    alucontrol[3:0] = alu4;
  end

  assign err     = err_q;
  assign state_o = state;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Directed bench for mips_multi_ctrl; the timeout scenario depends on MULTI_WAIT_TIMEOUT_EN.
module tb_mips_multi_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       memreq, pcen, memwrite, irwrite, regwrite;
  logic       alusrca, iord, memtoreg, regdst, zeroext;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;
  logic       err;
  logic [3:0] state_o;

  int tests_run = 0;
  int failed    = 0;

  logic [5:0] fn_tab [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
  logic [3:0] fn_alu [7] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010};
  logic [5:0] imm_op [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
  logic [3:0] imm_alu[4] = '{4'b0000, 4'b0100, 4'b0101, 4'b1010};
  logic       imm_zx [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [5:0] br_op  [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
  logic       br_zero[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       br_pcen[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  mips_multi_ctrl #(.ALUCTL_W(4), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memreq(memreq), .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .zeroext(zeroext),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (state_o !== 4'd0 || err !== 1'b0) begin
      failed++; $display("FAIL reset_state state=%0d err=%b exp state=0 err=0", state_o, err);
    end
    tests_run++;
    if ({memreq, pcen, irwrite, regwrite, memwrite} !== 5'b00000) begin
      failed++; $display("FAIL reset_enables got=%b exp=00000", {memreq, pcen, irwrite, regwrite, memwrite});
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({memreq, iord, alusrcb, alucontrol} !== 8'b1_0_01_0000) begin
      failed++; $display("FAIL reset_fetch got=%b exp=10010000", {memreq, iord, alusrcb, alucontrol});
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    op = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests_run++;
      if (state_o !== exp_st[i]) begin
        failed++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, state_o, exp_st[i]);
      end
      if (i == 0) begin
        tests_run++;
        if ({irwrite, pcen, pcsrc} !== 4'b1100) begin
          failed++; $display("FAIL lw_fetch got=%b exp=1100", {irwrite, pcen, pcsrc});
        end
      end
      if (i == 2) begin
        tests_run++;
        if ({alusrca, alusrcb, alucontrol} !== 7'b1_10_0000) begin
          failed++; $display("FAIL lw_memadr got=%b exp=1100000", {alusrca, alusrcb, alucontrol});
        end
      end
      if (i == 3) begin
        tests_run++;
        if ({memreq, iord, memwrite, regwrite} !== 4'b1100) begin
          failed++; $display("FAIL lw_memrd got=%b exp=1100", {memreq, iord, memwrite, regwrite});
        end
      end
      if (i == 4) begin
        tests_run++;
        if ({regwrite, memtoreg, regdst, memreq} !== 4'b1100) begin
          failed++; $display("FAIL lw_memwb got=%b exp=1100", {regwrite, memtoreg, regdst, memreq});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_wait();
    do_reset();
    op = 6'b101011; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if ({state_o, memreq, iord, memwrite} !== 7'b0101_110) begin
      failed++; $display("FAIL sw_wait got=%b exp=0101110", {state_o, memreq, iord, memwrite});
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({state_o, memreq, memwrite, regwrite} !== 7'b0101_110) begin
      failed++; $display("FAIL sw_write got=%b exp=0101110", {state_o, memreq, memwrite, regwrite});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (state_o !== 4'd0) begin
      failed++; $display("FAIL sw_done got=%0d exp=0", state_o);
    end
  endtask

  task automatic test_rtype();
    for (int k = 0; k < 7; k++) begin
      do_reset();
      op = 6'b000000; funct = fn_tab[k]; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      #1;
      tests_run++;
      if ({state_o, alusrca, alucontrol} !== {4'd6, 1'b1, fn_alu[k]}) begin
        failed++; $display("FAIL rtype_ex funct=%b got=%b exp=%b", fn_tab[k], {state_o, alusrca, alucontrol}, {4'd6, 1'b1, fn_alu[k]});
      end
      @(negedge clk);
      #1;
      tests_run++;
      if ({state_o, regwrite, regdst, memtoreg} !== 7'b0111_110) begin
        failed++; $display("FAIL rtype_wb funct=%b got=%b exp=0111110", fn_tab[k], {state_o, regwrite, regdst, memtoreg});
      end
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      op = br_op[k]; zero = br_zero[k]; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      #1;
      tests_run++;
      if ({state_o, pcen, pcsrc, alucontrol, alusrca} !== {4'd8, br_pcen[k], 2'b01, 4'b0010, 1'b1}) begin
        failed++; $display("FAIL branch op=%b zero=%b got=%b exp=%b", br_op[k], br_zero[k],
          {state_o, pcen, pcsrc, alucontrol, alusrca}, {4'd8, br_pcen[k], 2'b01, 4'b0010, 1'b1});
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (state_o !== 4'd0) begin
        failed++; $display("FAIL branch_done got=%0d exp=0", state_o);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_imm();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      op = imm_op[k]; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      #1;
      tests_run++;
      if ({state_o, alusrca, alusrcb, zeroext, alucontrol} !== {4'd9, 1'b1, 2'b10, imm_zx[k], imm_alu[k]}) begin
        failed++; $display("FAIL imm_ex op=%b got=%b exp=%b", imm_op[k],
          {state_o, alusrca, alusrcb, zeroext, alucontrol}, {4'd9, 1'b1, 2'b10, imm_zx[k], imm_alu[k]});
      end
      @(negedge clk);
      #1;
      tests_run++;
      if ({state_o, regwrite, regdst, memtoreg} !== 7'b1010_100) begin
        failed++; $display("FAIL imm_wb op=%b got=%b exp=1010100", imm_op[k], {state_o, regwrite, regdst, memtoreg});
      end
    end
  endtask

  task automatic test_fetch_wait_jump();
    do_reset();
    op = 6'b000010; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      tests_run++;
      if ({state_o, memreq, irwrite, pcen} !== {4'd0, 1'b1, (i == 3), (i == 3)}) begin
        failed++; $display("FAIL fetch_wait cyc=%0d got=%b exp=%b", i, {state_o, memreq, irwrite, pcen}, {4'd0, 1'b1, (i == 3), (i == 3)});
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if ({state_o, irwrite, pcen, memreq} !== 7'b0001_000) begin
      failed++; $display("FAIL fetch_decode got=%b exp=0001000", {state_o, irwrite, pcen, memreq});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({state_o, pcen, pcsrc} !== 7'b1011_1_10) begin
      failed++; $display("FAIL jump_ex got=%b exp=1011110", {state_o, pcen, pcsrc});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (state_o !== 4'd0) begin
      failed++; $display("FAIL jump_done got=%0d exp=0", state_o);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    op = 6'b111111; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0];
      #1;
      tests_run++;
      if ({state_o, err, memreq, pcen, irwrite, regwrite, memwrite} !== {4'd15, 1'b1, 5'b00000}) begin
        failed++; $display("FAIL illegal_op cyc=%0d got=%b exp=1111100000", i, {state_o, err, memreq, pcen, irwrite, regwrite, memwrite});
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({state_o, err} !== 5'b0000_0) begin
      failed++; $display("FAIL illegal_reset got=%b exp=00000", {state_o, err});
    end
    reset = 1'b0;
    do_reset();
    op = 6'b000000; funct = 6'b000000; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    tests_run++;
    if ({state_o, err, regwrite} !== 6'b1111_1_0) begin
      failed++; $display("FAIL illegal_funct got=%b exp=111110", {state_o, err, regwrite});
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    op = 6'b100011; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    tests_run++;
    if ({state_o, memreq} !== 5'b0011_1) begin
      failed++; $display("FAIL midacc_memrd got=%b exp=00111", {state_o, memreq});
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({state_o, memreq, regwrite, err} !== 7'b0000_000) begin
      failed++; $display("FAIL midacc_drop got=%b exp=0000000", {state_o, memreq, regwrite, err});
    end
    reset = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef MULTI_WAIT_TIMEOUT_EN
    do_reset();
    op = 6'b000010; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if ({state_o, err, memreq} !== 6'b0000_0_1) begin
        failed++; $display("FAIL timeout_wait cyc=%0d got=%b exp=000001", i, {state_o, err, memreq});
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({state_o, err, memreq, irwrite, pcen} !== 8'b1111_1_000) begin
      failed++; $display("FAIL timeout_error got=%b exp=11111000", {state_o, err, memreq, irwrite, pcen});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({state_o, err} !== 5'b1111_1) begin
      failed++; $display("FAIL timeout_sticky got=%b exp=11111", {state_o, err});
    end
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      @(negedge clk);
    end
    #1;
    tests_run++;
    if ({state_o, err} !== 5'b0001_0) begin
      failed++; $display("FAIL timeout_edge got=%b exp=00010", {state_o, err});
    end
    do_reset();
    op = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if ({state_o, err} !== 5'b0011_0) begin
        failed++; $display("FAIL timeout_memrd cyc=%0d got=%b exp=00110", i, {state_o, err});
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if ({state_o, err, memreq} !== 6'b1111_1_0) begin
      failed++; $display("FAIL timeout_memrd_err got=%b exp=111110", {state_o, err, memreq});
    end
`else
    do_reset();
    op = 6'b000010; mem_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      tests_run++;
      if ({state_o, err, memreq} !== 6'b0000_0_1) begin
        failed++; $display("FAIL nowatchdog_wait cyc=%0d got=%b exp=000001", i, {state_o, err, memreq});
      end
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_branch();
    test_imm();
    test_fetch_wait_jump();
    test_illegal();
    test_reset_mid_access();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
